// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side plus registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder slice, a carry flop closing the loop,
// LSB-first shifting, one add every WIDTH+1 cycles.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_nxt;
    logic             c_ff;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s, fa_c;
    logic             load;

    fulladder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(c_ff), .s(fa_s), .c(fa_c));

    // Only WIDTH-1 partial bits need storing; the last bit comes straight from the slice.
    assign r_nxt = {fa_s, r_sr};
    assign load  = (state == IDLE || state == DONE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            c_ff   <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            c_ff <= bus.cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nxt[WIDTH-1:1];
            c_ff <= fa_c;
            if (cnt == LAST) begin
                sum_q  <= r_nxt;
                cout_q <= fa_c;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder against a plain a+b+cin model.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge and waits (bounded) for done; lat counts edges from accept to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co, output int lat, output int busy_cnt);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom);
        lat = 0; busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        s = bus.sum; co = bus.cout;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b cout=%b sum=%h want all 0", bus.busy, bus.done, bus.cout, bus.sum);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h3C, 8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] vb [4] = '{8'h5A, 8'h01, 8'hFF, 8'h00};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic         co;
        int           lat, bc;
        logic [W:0]   exp;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], s, co, lat, bc);
            exp = {1'b0, va[i]} + {1'b0, vb[i]} + {8'h00, vc[i]};
            total++;
            if ({co, s} !== exp) begin
                bad++;
                $display("FAIL directed%0d result: got %b_%h want %b_%h", i, co, s, exp[W], exp[W-1:0]);
            end
            total++;
            if (lat != W || bc != W) begin
                bad++;
                $display("FAIL directed%0d timing: latency=%0d busy=%0d want %0d/%0d", i, lat, bc, W, W);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [W-1:0] s = '0;
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin bus.a = 8'hAA; bus.start = 1'b1; end
            if (i == 4) bus.start = 1'b0;
            if (bus.done) begin dones++; s = bus.sum; end
            tick();
        end
        total++;
        if (s !== 8'h30 || dones != 1) begin
            bad++;
            $display("FAIL ignore_start: sum=%h dones=%0d want 30/1", s, dones);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
            bad++;
            $display("FAIL reset_abort: busy=%b done=%b cout=%b sum=%h want all 0", bus.busy, bus.done, bus.cout, bus.sum);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done || bus.busy) dones++;
            tick();
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_abort_quiet: activity cycles=%0d want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, t1 = -1, t2 = -1;
        logic [W-1:0] s1 = '0, s2 = '0;
        logic c1 = 1'b1, c2 = 1'b1;
        bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 8'h7F;
        while (t2 < 0 && cyc < 40) begin
            if (bus.done) begin
                if (t1 < 0) begin t1 = cyc; s1 = bus.sum; c1 = bus.cout; end
                else begin t2 = cyc; s2 = bus.sum; c2 = bus.cout; bus.start = 1'b0; end
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        total++;
        if (s1 !== 8'h02 || c1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: got %b_%h want 0_02", c1, s1);
        end
        total++;
        if (s2 !== 8'h80 || c2 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got %b_%h want 0_80", c2, s2);
        end
        total++;
        if (t1 < 0 || t2 - t1 != W + 1) begin
            bad++;
            $display("FAIL b2b_spacing: t1=%0d t2=%0d want gap %0d", t1, t2, W + 1);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic         c, co;
        int           lat, bc;
        logic [W:0]   exp;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
            run_op(a, b, c, s, co, lat, bc);
            total++;
            if ({co, s} !== exp || lat != W) begin
                bad++;
                $display("FAIL random%0d: %h+%h+%b got %b_%h lat=%0d want %b_%h lat=%0d",
                         i, a, b, c, co, s, lat, exp[W], exp[W-1:0], W);
            end
            if (i % 3 == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
